// File: rtl/riscv_bp_pkg.sv
// Shared types and constants for the branch predictor: 2-bit counter encoding,
// reset and allocation values.
package riscv_bp_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;

    localparam ctr2_t CTR_RESET = CTR_WNT;
    localparam ctr2_t CTR_ALLOC = CTR_WT;

    // Upper counter bit is the taken prediction
    function automatic logic ctr_predicts_taken(input ctr2_t ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational 2-bit saturating counter step: increment on taken, decrement on
// not-taken, holding at ST and SNT respectively.
module bp_sat_counter
    import riscv_bp_pkg::*;
(
    input  ctr2_t cur_i,
    input  logic  taken_i,
    output ctr2_t next_o
);

    always_comb begin
        next_o = cur_i;
        if (taken_i) begin
            if (cur_i != CTR_ST) begin
                next_o = ctr2_t'(cur_i + 2'd1);
            end
        end else begin
            if (cur_i != CTR_SNT) begin
                next_o = ctr2_t'(cur_i - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit counter BHT, combinational lookup, trained at the
// clock edge. Define BRANCH_PREDICTOR_GSHARE_EN to index the BHT with pc ^ GHR.
module branch_predictor
    import riscv_bp_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned GHR_W   = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pred_hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [XLEN-1:0]   target_q [ENTRIES];
    ctr2_t             ctr_q    [ENTRIES];

    logic [IDX-1:0]    lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX-1:0]    lk_bht_idx;
    logic              lk_hit;

    logic [IDX-1:0]    up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic [IDX-1:0]    up_bht_idx;
    logic              up_hit;
    logic              up_en;
    ctr2_t             up_ctr_next;

    logic              unused_pc_bits;

    assign lk_idx = pc_i[IDX+1:2];
    assign lk_tag = pc_i[XLEN-1:IDX+2];
    assign up_idx = upd_pc_i[IDX+1:2];
    assign up_tag = upd_pc_i[XLEN-1:IDX+2];
    assign up_en  = upd_valid_i & start_i;

    // Instruction-aligned PCs never use the low two bits
    assign unused_pc_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    // BHT is indexed by pc ^ history; the update uses the pre-shift history
    assign lk_bht_idx = lk_idx ^ IDX'(ghr_q);
    assign up_bht_idx = up_idx ^ IDX'(ghr_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ghr_q <= '0;
        end else if (up_en) begin
            ghr_q <= GHR_W'({ghr_q, upd_taken_i});
        end
    end
`else
    localparam int unsigned UNUSED_GHR_W = GHR_W;

    assign lk_bht_idx = lk_idx;
    assign up_bht_idx = up_idx;
`endif

    // Lookup: purely combinational against current state, no bypass
    always_comb begin
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_hit_o    = lk_hit;
        pred_taken_o  = lk_hit & ctr_predicts_taken(ctr_q[lk_bht_idx]) & start_i;
        pred_target_o = lk_hit ? target_q[lk_idx] : '0;
    end

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    bp_sat_counter u_sat_counter (
        .cur_i   (ctr_q[up_bht_idx]),
        .taken_i (upd_taken_i),
        .next_o  (up_ctr_next)
    );

    // Valid bits and counters need reset; the whole table is cleared at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (up_en) begin
            if (up_hit) begin
                ctr_q[up_bht_idx] <= up_ctr_next;
            end else if (upd_taken_i) begin
                valid_q[up_idx]   <= 1'b1;
                ctr_q[up_bht_idx] <= CTR_ALLOC;
            end
        end
    end

    // Tag and target are qualified by valid, so they carry no reset
    always_ff @(posedge clk_i) begin
        if (up_en && upd_taken_i) begin
            target_q[up_idx] <= upd_target_i;
            if (!up_hit) begin
                tag_q[up_idx] <= up_tag;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build), with a
// history-pattern check when BRANCH_PREDICTOR_GSHARE_EN is defined.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.XLEN(32), .ENTRIES(64), .GHR_W(6)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .pc_i          (pc),
        .pred_hit_o    (pred_hit),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .upd_valid_i   (upd_valid),
        .upd_pc_i      (upd_pc),
        .upd_taken_i   (upd_taken),
        .upd_target_i  (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One accepted update, driven at negedge and retired just after posedge
    task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = p;
        upd_taken  = t;
        upd_target = tgt;
        @(posedge clk);
        #1;
        upd_valid  = 1'b0;
    endtask

    task automatic look(input logic [31:0] p);
        pc = p;
        #1;
    endtask

    task automatic check_pred(input string tag, input logic h, input logic t, input logic [31:0] tgt);
        check({tag, ".hit"},    32'(pred_hit),   32'(h));
        check({tag, ".taken"},  32'(pred_taken), 32'(t));
        check({tag, ".target"}, pred_target,     tgt);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        pc         = 32'h0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        look(32'h100);
        check_pred("reset", 1'b0, 1'b0, 32'h0);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
        begin
            int ok = 0;
            logic t;
            for (int i = 0; i < 80; i++) begin
                t = (i % 2 == 0);
                look(32'h100);
                if (i >= 20 && pred_taken == t) ok++;
                upd(32'h100, t, 32'h180);
            end
            check("gshare_accuracy_ge_54_of_60", 32'(ok >= 54), 32'd1);
        end
`else
        // Allocation lands at WT
        upd(32'h100, 1'b1, 32'h180);
        look(32'h100);
        check_pred("alloc", 1'b1, 1'b1, 32'h180);

        // WT -> WNT -> SNT
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100);
        check_pred("down_snt", 1'b1, 1'b0, 32'h180);

        // SNT -> WNT -> WT -> ST
        upd(32'h100, 1'b1, 32'h180);
        upd(32'h100, 1'b1, 32'h180);
        upd(32'h100, 1'b1, 32'h180);
        look(32'h100);
        check_pred("up_st", 1'b1, 1'b1, 32'h180);

        // 0x200 shares index 0 with 0x100 but has a different tag
        upd(32'h200, 1'b1, 32'h2a0);
        look(32'h100);
        check("alias_evicted.hit", 32'(pred_hit), 32'd0);
        look(32'h200);
        check_pred("alias_new", 1'b1, 1'b1, 32'h2a0);

        // Re-allocate 0x100 (WT), then one not-taken to reach WNT
        upd(32'h100, 1'b1, 32'h180);
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100);
        check("wnt_before.taken", 32'(pred_taken), 32'd0);

        // Same-cycle lookup sees pre-update state
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 32'h100;
        upd_taken  = 1'b1;
        upd_target = 32'h180;
        pc         = 32'h100;
        #1;
        check("same_cycle.taken", 32'(pred_taken), 32'd0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        check("next_cycle.taken", 32'(pred_taken), 32'd1);

        // start low forces taken to 0 and blocks updates
        @(negedge clk);
        start = 1'b0;
        look(32'h100);
        check("start_low.hit", 32'(pred_hit), 32'd1);
        check("start_low.taken", 32'(pred_taken), 32'd0);
        upd(32'h104, 1'b1, 32'h1c0);
        upd(32'h100, 1'b0, 32'h0);
        start = 1'b1;
        look(32'h104);
        check("start_low_no_alloc.hit", 32'(pred_hit), 32'd0);
        look(32'h100);
        check("start_low_no_step.taken", 32'(pred_taken), 32'd1);

        // Asynchronous reset mid-cycle clears the lookup before the next edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_pred("async_rst", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        look(32'h100);
        check("after_rst.hit", 32'(pred_hit), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V pipeline. It is the parametrised successor to the fixed predict-not-taken / flush-in-ID scheme. It combines a direct-mapped branch target buffer (BTB) with a table of 2-bit saturating counters (BHT). The predictor is looked up combinationally with the IF-stage PC and trained at the clock edge by the ID-stage branch resolution.

## Interface
Parameters:
- XLEN, 32: address/data width.
- ENTRIES, 64: BTB and BHT depth. Must be a power of two, ≥4. IDX = log2(ENTRIES).
- GHR_W, 6: global history length. Used only with GSHARE_EN. Must satisfy 1 ≤ GHR_W ≤ IDX.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  update enable. When low, updates are ignored and pred_taken_o is forced to 0.
- pc_i  in  XLEN  IF-stage PC to predict.
- pred_hit_o  out  1  BTB entry valid and tag matches pc_i.
- pred_taken_o  out  1  predict taken: pred_hit_o & counter[1] & start_i.
- pred_target_o  out  XLEN  stored target on hit, else 0.
- upd_valid_i  in  1  ID stage resolved a conditional branch this cycle.
- upd_pc_i  in  XLEN  PC of the resolved branch.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  XLEN  actual taken target (IFID pc + imm<<1).

## Operation
- BTB index = pc[IDX+1:2]. Tag = pc[XLEN-1:IDX+2]. Per entry: valid, tag, target (XLEN), plus one 2-bit counter in the BHT.
- BHT index = BTB index, or the GSHARE index when GSHARE_EN is defined.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11. Taken increments and saturates at 11; not-taken decrements and saturates at 00.
- Lookup is purely combinational from pc_i and the current state. No registered outputs.
- Update applies when upd_valid_i & start_i:
  - Hit (valid & tag match at upd_pc_i): step the counter by upd_taken_i. If taken, rewrite the target with upd_target_i.
  - Miss and taken: allocate the entry, overwriting any previous occupant. Set valid=1, tag, target, counter=WT.
  - Miss and not-taken: no change.
- Reset (rst_i high, any time, including mid-update): all valid=0, all counters=WNT, GHR=0. The block is trained from scratch after release.
- Outputs immediately after reset: pred_hit_o=0, pred_taken_o=0, pred_target_o=0.
- upd_valid_i with start_i low: no state change, GHR unchanged.

## Timing
- Lookup latency: 0 cycles (same-cycle, pc_i → outputs).
- Update latency: 1 cycle. A lookup of the same index in the update cycle sees the pre-update state; there is no bypass.
- Updates write one entry per cycle, so there is no read/write port conflict beyond the rule above.
- Aliasing: two PCs with the same index and different tags evict each other on taken allocation. Counter history is not preserved across eviction.

## Configuration
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- When defined:
  - A GHR_W-bit global history register shifts left by one on every accepted update, inserting upd_taken_i at bit 0.
  - BHT index = pc[IDX+1:2] XOR zero-extended GHR, for both lookup and update. The update uses the GHR value before the shift.
  - The BTB stays PC-indexed. On allocation, the counter at the GSHARE index is set to WT.
- When undefined: there is no GHR register, and the BHT is indexed by pc[IDX+1:2] only.

## Structure
- Shared package riscv_bp_pkg holds:
  - the counter encoding constants (SNT/WNT/WT/ST);
  - a ctr2_t typedef;
  - reset value CTR_RESET=WNT;
  - allocation value CTR_ALLOC=WT.
- One sub-module: bp_sat_counter. It is combinational and maps (ctr2_t current, taken) to ctr2_t next with saturation. It is instantiated once on the update path.
- The BTB and BHT arrays live in the top module as register arrays, because they need asynchronous reset.

## Test plan
- Reset, then pc_i=0x100 → pred_hit_o=0, pred_taken_o=0, pred_target_o=0.
- Update pc=0x100, taken, target=0x180; next cycle pc_i=0x100 → hit=1, taken=1, target=0x180.
- Counter saturation:
  - Starting from the previous state (counter WT), apply two not-taken updates at 0x100, then look up → taken=0 (counter SNT), hit=1.
  - Then three taken updates → taken=1 (counter ST).
- Alias eviction (ENTRIES=64):
  - Taken update at 0x100, then taken update at 0x200 (same index, different tag).
  - Lookup 0x100 → hit=0. Lookup 0x200 → hit=1, target=0x200's target.
- Same-cycle update and lookup of 0x100 from counter WNT with taken → pred_taken_o=0 in that cycle, 1 in the next.
- Two cases:
  - start_i=0 during a taken update → no state change.
  - rst_i asserted asynchronously mid-cycle after training → pred_hit_o drops to 0 before the next clock edge.
- With BRANCH_PREDICTOR_GSHARE_EN defined, apply alternating T/NT updates on one PC → after warm-up, predictions match the outcome ≥90% of the time.
